fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/proc_ctrl_pkg.sv | 17 +
 rtl/fetch_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the fetch/execute control sequencer: state encoding and
// default fetch/interrupt vectors.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        StBoot   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StUpdate = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [15:0] RESET_VECTOR_DFLT = 16'h0000;
    localparam logic [15:0] IRQ_VECTOR_DFLT   = 16'h0010;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer. Drives memory reads, instruction register
// load, execute handshake and program-counter updates (jump, taken branch, reset vector).
// Optional interrupt entry/return is compiled in with `define FETCH_SEQUENCER_IRQ_EN.
module fetch_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DFLT,
    parameter logic [15:0] IRQ_VECTOR   = IRQ_VECTOR_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic        ir_load,
    input  logic        op_jump,
    input  logic        op_branch,
    input  logic        cond_true,
    input  logic        op_halt,
    input  logic [15:0] jump_target,
    output logic        exec_start,
    input  logic        exec_done,
    output logic        halted,
    output logic        writePC,
    output logic        incrementPC,
    output logic [15:0] pc_data,
`ifdef FETCH_SEQUENCER_IRQ_EN
    input  logic        irq,
    input  logic        op_reti,
    output logic        irq_ack,
    output logic [15:0] epc,
`endif
    input  logic [15:0] pc_q
);

    state_e      state_q, state_d;
    logic        jump_q, jump_d;
    logic        taken_q, taken_d;
    logic        halt_q, halt_d;
    logic [15:0] target_q, target_d;
    // Set after the first EXEC cycle so exec_start fires only once per instruction.
    logic        exec_busy_q, exec_busy_d;

    logic        mem_req_c, ld_c, wr_c, es_c, halted_c;
    logic [15:0] pc_val;

`ifdef FETCH_SEQUENCER_IRQ_EN
    logic        reti_q, reti_d;
    logic        ien_q, ien_d;
    logic [15:0] epc_q, epc_d;
    logic        ack_c;
    logic        irq_take;
    assign irq_take = irq && ien_q;
`endif

    // Next-state, flag capture and raw (ungated) strobe generation.
    always_comb begin
        state_d     = state_q;
        jump_d      = jump_q;
        taken_d     = taken_q;
        halt_d      = halt_q;
        target_d    = target_q;
        exec_busy_d = exec_busy_q;
        mem_req_c   = 1'b0;
        ld_c        = 1'b0;
        wr_c        = 1'b0;
        es_c        = 1'b0;
        halted_c    = 1'b0;
        pc_val      = '0;
`ifdef FETCH_SEQUENCER_IRQ_EN
        reti_d      = reti_q;
        ien_d       = ien_q;
        epc_d       = epc_q;
        ack_c       = 1'b0;
`endif
        unique case (state_q)
            StBoot: begin
                wr_c    = 1'b1;
                pc_val  = RESET_VECTOR;
                state_d = StFetch;
            end
            StFetch: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ld_c    = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                jump_d      = op_jump;
                taken_d     = op_branch & cond_true;
                halt_d      = op_halt;
                target_d    = jump_target;
                exec_busy_d = 1'b0;
`ifdef FETCH_SEQUENCER_IRQ_EN
                reti_d      = op_reti;
`endif
                state_d     = StExec;
            end
            StExec: begin
                es_c        = ~exec_busy_q;
                exec_busy_d = 1'b1;
                if (exec_done) state_d = StUpdate;
            end
            StUpdate: begin
                state_d = StFetch;
                if (halt_q) begin
                    state_d = StHalt;
                end
`ifdef FETCH_SEQUENCER_IRQ_EN
                else if (reti_q) begin
                    wr_c   = 1'b1;
                    pc_val = epc_q;
                    ien_d  = 1'b1;
                end
`endif
                else if (taken_q || jump_q) begin
                    wr_c   = 1'b1;
                    pc_val = target_q;
                end
`ifdef FETCH_SEQUENCER_IRQ_EN
                else if (irq_take) begin
                    wr_c   = 1'b1;
                    pc_val = IRQ_VECTOR;
                    ack_c  = 1'b1;
                    epc_d  = pc_q;
                    ien_d  = 1'b0;
                end
`endif
            end
            StHalt: begin
                halted_c = 1'b1;
`ifdef FETCH_SEQUENCER_IRQ_EN
                if (irq_take) begin
                    wr_c    = 1'b1;
                    pc_val  = IRQ_VECTOR;
                    ack_c   = 1'b1;
                    epc_d   = pc_q;
                    ien_d   = 1'b0;
                    state_d = StFetch;
                end
`endif
            end
            default: state_d = StBoot;
        endcase
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            jump_q      <= 1'b0;
            taken_q     <= 1'b0;
            halt_q      <= 1'b0;
            target_q    <= '0;
            exec_busy_q <= 1'b0;
`ifdef FETCH_SEQUENCER_IRQ_EN
            reti_q      <= 1'b0;
            ien_q       <= 1'b1;
            epc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            jump_q      <= jump_d;
            taken_q     <= taken_d;
            halt_q      <= halt_d;
            target_q    <= target_d;
            exec_busy_q <= exec_busy_d;
`ifdef FETCH_SEQUENCER_IRQ_EN
            reti_q      <= reti_d;
            ien_q       <= ien_d;
            epc_q       <= epc_d;
`endif
        end
    end

    // Reset masks every output immediately so an aborted operation issues no strobe.
    assign mem_req     = mem_req_c & ~rst;
    assign ir_load     = ld_c & ~rst;
    assign incrementPC = ld_c & ~rst;
    assign writePC     = wr_c & ~rst;
    assign pc_data     = writePC ? pc_val : '0;
    assign exec_start  = es_c & ~rst;
    assign halted      = halted_c & ~rst;
`ifdef FETCH_SEQUENCER_IRQ_EN
    assign irq_ack     = ack_c & ~rst;
    assign epc         = rst ? '0 : epc_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus hand-written corner sequences.
// Interrupt checks are included when FETCH_SEQUENCER_IRQ_EN is defined.
module tb_fetch_sequencer;

    typedef struct packed {
        logic        rst, rdy, done, jump, branch, cond, halt, irq, reti;
        logic [15:0] tgt, pc;
    } in_t;

    typedef struct packed {
        logic        req, ld, inc, wr;
        logic [15:0] pcd;
        logic        es, hl, ack;
        logic [15:0] epc;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  e;
        string name;
    } vec_t;

    localparam bit [3:0] FN  = 4'b0000; // {jump, branch, cond, halt}
    localparam bit [3:0] FJ  = 4'b1000;
    localparam bit [3:0] FB  = 4'b0110;
    localparam bit [3:0] FBN = 4'b0100;
    localparam bit [3:0] FH  = 4'b0001;
    localparam bit [3:0] FHJ = 4'b1001;

    logic        clk = 1'b0;
    logic        rst, mem_ready, op_jump, op_branch, cond_true, op_halt, exec_done;
    logic [15:0] jump_target, pc_q;
    logic        irq, op_reti;
    logic        mem_req, ir_load, exec_start, halted, writePC, incrementPC;
    logic [15:0] pc_data;
    logic        ack_w;
    logic [15:0] epc_w;

    int checks = 0;
    int errors = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .ir_load    (ir_load),
        .op_jump    (op_jump),
        .op_branch  (op_branch),
        .cond_true  (cond_true),
        .op_halt    (op_halt),
        .jump_target(jump_target),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .halted     (halted),
        .writePC    (writePC),
        .incrementPC(incrementPC),
        .pc_data    (pc_data),
`ifdef FETCH_SEQUENCER_IRQ_EN
        .irq        (irq),
        .op_reti    (op_reti),
        .irq_ack    (ack_w),
        .epc        (epc_w),
`endif
        .pc_q       (pc_q)
    );

`ifndef FETCH_SEQUENCER_IRQ_EN
    assign ack_w = 1'b0;
    assign epc_w = 16'h0000;
`endif

    function automatic in_t mi(bit r, bit rdy, bit done, bit [3:0] f, logic [15:0] tgt,
                               logic [15:0] pc, bit iq, bit rt);
        in_t v;
        v.rst = r; v.rdy = rdy; v.done = done;
        v.jump = f[3]; v.branch = f[2]; v.cond = f[1]; v.halt = f[0];
        v.tgt = tgt; v.pc = pc; v.irq = iq; v.reti = rt;
        return v;
    endfunction

    function automatic out_t mo(bit req, bit ld, bit wr, logic [15:0] pcd, bit es, bit hl,
                                bit ack, logic [15:0] epc);
        out_t v;
        v.req = req; v.ld = ld; v.inc = ld; v.wr = wr; v.pcd = pcd;
        v.es = es; v.hl = hl; v.ack = ack; v.epc = epc;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare mid-cycle, advance.
    task automatic step(input in_t i, input out_t e, input string name);
        out_t got, ex;
        rst = i.rst; mem_ready = i.rdy; exec_done = i.done;
        op_jump = i.jump; op_branch = i.branch; cond_true = i.cond; op_halt = i.halt;
        jump_target = i.tgt; pc_q = i.pc; irq = i.irq; op_reti = i.reti;
        exp_q.push_back(e);
        #1;
        got = '{req: mem_req, ld: ir_load, inc: incrementPC, wr: writePC, pcd: pc_data,
                es: exec_start, hl: halted, ack: ack_w, epc: epc_w};
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL %s: got req=%b ld=%b inc=%b wr=%b pcd=%h es=%b hl=%b ack=%b epc=%h ; required req=%b ld=%b inc=%b wr=%b pcd=%h es=%b hl=%b ack=%b epc=%h",
                     name, got.req, got.ld, got.inc, got.wr, got.pcd, got.es, got.hl, got.ack,
                     got.epc, ex.req, ex.ld, ex.inc, ex.wr, ex.pcd, ex.es, ex.hl, ex.ack, ex.epc);
        end
        @(negedge clk);
    endtask

    task automatic add(input in_t i, input out_t e, input string name);
        vecs.push_back('{i: i, e: e, name: name});
    endtask

    initial begin
        out_t z;
        z = mo(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        rst = 1; mem_ready = 0; exec_done = 0; op_jump = 0; op_branch = 0; cond_true = 0;
        op_halt = 0; jump_target = 0; pc_q = 0; irq = 0; op_reti = 0;
        @(negedge clk);

        add(mi(1, 0, 0, FN, 0, 0, 0, 0), z, "reset_idle");
        add(mi(1, 1, 1, FN, 0, 0, 0, 0), z, "reset_ignores_inputs");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h0000, 0, 0, 0, 0), "boot_reset_vector");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 0, 0), "fetch_wait1");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 0, 0), "fetch_wait2");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 0, 0), "fetch_wait3");
        add(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 0), "fetch_ready");
        add(mi(0, 0, 1, FB, 16'h0042, 0, 0, 0), z, "decode_branch_done_ignored");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 0), "exec_start");
        add(mi(0, 1, 0, FN, 0, 0, 0, 0), z, "exec_wait_ready_ignored");
        add(mi(0, 0, 1, FN, 0, 0, 0, 0), z, "exec_done");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h0042, 0, 0, 0, 0), "update_taken");
        add(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 0), "fetch2");
        add(mi(0, 0, 0, FBN, 16'h0077, 0, 0, 0), z, "decode_not_taken");
        add(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 0), "exec_one_cycle");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), z, "update_not_taken");
        add(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 0), "fetch3");
        add(mi(0, 0, 0, FJ, 16'h1234, 0, 0, 0), z, "decode_jump");
        add(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 0), "exec_jump");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h1234, 0, 0, 0, 0), "update_jump");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 0, 0), "fetch4_wait");
        add(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 0), "fetch4");
        add(mi(0, 0, 0, FHJ, 16'h5555, 0, 0, 0), z, "decode_halt");
        add(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 0), "exec_halt");
        add(mi(0, 0, 0, FN, 0, 0, 0, 0), z, "update_halt_beats_jump");

        for (int k = 0; k < vecs.size(); k++) step(vecs[k].i, vecs[k].e, vecs[k].name);

        // HALT persists with no strobes regardless of inputs.
        for (int k = 0; k < 10; k++)
            step(mi(0, 1, 1, FJ, 16'h0abc, 0, 0, 0), mo(0, 0, 0, 0, 0, 1, 0, 0), "halt_hold");
        step(mi(1, 0, 0, FN, 0, 0, 0, 0), z, "halt_reset");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h0000, 0, 0, 0, 0), "boot_after_halt");

        // Reset in the first EXEC cycle suppresses exec_start.
        step(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 0), "fetch_pre_abort");
        step(mi(0, 0, 0, FJ, 16'h00aa, 0, 0, 0), z, "decode_pre_abort");
        step(mi(1, 0, 1, FN, 0, 0, 0, 0), z, "exec_abort");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h0000, 0, 0, 0, 0), "boot_after_exec");

        // Reset during a FETCH wait suppresses ir_load.
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 0, 0), "fetch_wait_abort");
        step(mi(1, 1, 0, FN, 0, 0, 0, 0), z, "fetch_abort");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h0000, 0, 0, 0, 0), "boot_after_fetch");

`ifdef FETCH_SEQUENCER_IRQ_EN
        step(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 0), "i_fetch1");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), z, "i_decode1");
        step(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 0), "i_exec1");
        step(mi(0, 0, 0, FN, 0, 16'h0105, 1, 0), mo(0, 0, 1, 16'h0010, 0, 0, 1, 0), "irq_entry");
        step(mi(0, 1, 0, FN, 0, 0, 1, 0), mo(1, 1, 0, 0, 0, 0, 0, 16'h0105), "i_fetch2_epc");
        step(mi(0, 0, 0, FN, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 0, 16'h0105), "i_decode2");
        step(mi(0, 0, 1, FN, 0, 0, 1, 0), mo(0, 0, 0, 0, 1, 0, 0, 16'h0105), "i_exec2");
        step(mi(0, 0, 0, FN, 0, 16'h0333, 1, 0), mo(0, 0, 0, 0, 0, 0, 0, 16'h0105),
             "irq_masked");
        step(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 16'h0105), "i_fetch3");
        step(mi(0, 0, 0, FJ, 16'h0999, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 0, 16'h0105), "i_dec_reti");
        step(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 16'h0105), "i_exec3");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h0105, 0, 0, 0, 16'h0105), "reti");
        step(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 16'h0105), "i_fetch4");
        step(mi(0, 0, 0, FJ, 16'h0300, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 16'h0105), "i_dec_jmp");
        step(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 16'h0105), "i_exec4");
        step(mi(0, 0, 0, FN, 0, 16'h0222, 1, 0), mo(0, 0, 1, 16'h0300, 0, 0, 0, 16'h0105),
             "jump_beats_irq");
        step(mi(0, 1, 0, FN, 0, 0, 1, 0), mo(1, 1, 0, 0, 0, 0, 0, 16'h0105), "i_fetch5");
        step(mi(0, 0, 0, FN, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 0, 16'h0105), "i_decode5");
        step(mi(0, 0, 1, FN, 0, 0, 1, 0), mo(0, 0, 0, 0, 1, 0, 0, 16'h0105), "i_exec5");
        step(mi(0, 0, 0, FN, 0, 16'h0303, 1, 0), mo(0, 0, 1, 16'h0010, 0, 0, 1, 16'h0105),
             "irq_later");
        step(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 16'h0303), "i_fetch6");
        step(mi(0, 0, 0, FN, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 0, 16'h0303), "i_dec_reti2");
        step(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 16'h0303), "i_exec6");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 1, 16'h0303, 0, 0, 0, 16'h0303), "reti2");
        step(mi(0, 1, 0, FN, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 16'h0303), "i_fetch7");
        step(mi(0, 0, 0, FH, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 16'h0303), "i_dec_halt");
        step(mi(0, 0, 1, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 0, 16'h0303), "i_exec7");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 16'h0303), "i_upd_halt");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1, 0, 16'h0303), "i_halt");
        step(mi(0, 0, 0, FN, 0, 16'h0400, 1, 0), mo(0, 0, 1, 16'h0010, 0, 1, 1, 16'h0303),
             "halt_irq_entry");
        step(mi(0, 0, 0, FN, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 0, 16'h0400), "halt_irq_fetch");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
